seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It shares the single `hexto7segment` decoder instance among four digits. Each slot it presents one nibble on the decoder input, registers the returned pattern, and drives the matching anode. It sits between the board-level value source (switches/counters) and the display pins.

---
 rtl/seg_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment digit decoder plus a four-digit scan controller that shares it across digits.
// Pins are registered (one cycle behind the scan index); load is always accepted, there is no backpressure.
module hexto7segment (
    input  logic [3:0] x,
    output logic [6:0] r
);
    always_comb begin
        // active-low segments, bit order {g,f,e,d,c,b,a}
        case (x)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
    end
endmodule

module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_mask,
    input  logic        lz_en,
    output logic [3:0]  dec_x,
    input  logic [6:0]  dec_r,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          frame_done_q, frame_done_d;

    logic tc, frame_end, in_guard, upper_zero, blanked;

    assign tc        = (div_cnt_q == CW'(REFRESH_DIV - 1));
    assign frame_end = tc && (idx_q == 2'd3);
    assign in_guard  = (int'(div_cnt_q) < GUARD);
    assign dec_x     = disp_q[{idx_q, 2'b00} +: 4];

    // Leading-zero test looks at the current digit and everything to its left.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(idx_q) && disp_q[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        blanked = blank_mask[idx_q] | (lz_en & (idx_q != 2'd0) & upper_zero);
    end

    always_comb begin
        div_cnt_d    = tc ? '0 : div_cnt_q + 1'b1;
        idx_d        = tc ? idx_q + 2'd1 : idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        // Transfer happens before the same-cycle load so the older pending value wins this frame.
        if (frame_end && pend_v_q) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end
        if (load) begin
            pend_d   = value;
            pend_v_d = 1'b1;
        end

        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!in_guard) begin
            an_d = ~(4'b0001 << idx_q);
            if (!blanked) begin
                seg_d = dec_r;
                dp_d  = ~dp_in[idx_q];
            end
        end
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_v_q     <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed phases then random traffic, checked each cycle
// against a frame-position model of the display.
module tb_seg_scan_ctrl;
    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst, load, lz_en, dp, frame_done;
    logic [15:0] value;
    logic [3:0]  dp_in, blank_mask, dec_x, an;
    logic [6:0]  dec_r, seg;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .GUARD(GRD)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .blank_mask(blank_mask), .lz_en(lz_en), .dec_x(dec_x), .dec_r(dec_r),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    hexto7segment dec (.x(dec_x), .r(dec_r));

    // Lit segments, active-high {g..a}, standard hex glyphs.
    logic [6:0] pat_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          total = 0, bad = 0;
    int          m_cnt, cyc, rel_cnt, first_lit, last_fd;
    logic [15:0] m_disp, m_pend;
    bit          m_pv;
    string       phase;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s: got %h want %h", phase, tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] v);
        logic [3:0] e_an, d;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        int         slot, ph, zeros;
        bit         blk;
        rst = r; load = ld; value = v;
        @(posedge clk);
        #1;
        cyc++;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        if (r) begin
            m_cnt = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 0;
            rel_cnt = 0; first_lit = -1; last_fd = -1;
        end else begin
            slot = m_cnt / DIV;
            ph   = m_cnt % DIV;
            if (ph >= GRD) begin
                d    = m_disp[4*slot +: 4];
                blk  = blank_mask[slot] || (lz_en && slot >= 1 && (m_disp >> (4*slot)) == 16'h0);
                e_an = ~(4'b0001 << slot);
                if (!blk) begin
                    e_seg = ~pat_on[d];
                    e_dp  = ~dp_in[slot];
                end
            end
            e_fd = (m_cnt == FRAME - 1);
            if (e_fd && m_pv) begin
                m_disp = m_pend;
                m_pv   = 0;
            end
            if (ld) begin
                m_pend = v;
                m_pv   = 1;
            end
            m_cnt = (m_cnt + 1) % FRAME;
            rel_cnt++;
        end
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("dp", dp, e_dp);
        check("frame_done", frame_done, e_fd);
        check("dec_x", dec_x, m_disp[4*(m_cnt/DIV) +: 4]);
        zeros = 0;
        for (int k = 0; k < 4; k++) if (an[k] === 1'b0) zeros++;
        check("one_anode", 16'(zeros <= 1), 16'h1);
        if (!r && an !== 4'hF && first_lit < 0) first_lit = rel_cnt;
        if (frame_done === 1'b1) begin
            if (last_fd >= 0) check("fd_period", 16'(cyc - last_fd), 16'(FRAME));
            last_fd = cyc;
        end
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] rv;
        rst = 1'b1; load = 1'b0; value = 16'h0; dp_in = 4'h0; blank_mask = 4'h0; lz_en = 1'b0;
        cyc = 0; m_cnt = 0; m_disp = 0; m_pend = 0; m_pv = 0;
        rel_cnt = 0; first_lit = -1; last_fd = -1;

        phase = "reset";
        repeat (2) step(1'b1, 1'b0, 16'h0);
        phase = "prescan";
        step(1'b0, 1'b1, 16'h9876);
        repeat (44) step(1'b0, 1'b0, 16'h0);
        phase = "reset_mid";
        step(1'b1, 1'b1, 16'h4444);
        repeat (2) step(1'b1, 1'b0, 16'h0);
        phase = "post_rst";
        repeat (10) step(1'b0, 1'b0, 16'h0);
        check("first_lit", 16'(first_lit), 16'd3);

        phase = "scan";
        step(1'b0, 1'b1, 16'h1234);
        repeat (3 * FRAME) step(1'b0, 1'b0, 16'h0);

        phase = "tear";
        while (m_cnt != DIV + GRD + 1) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'hABCD);
        repeat (2 * FRAME) step(1'b0, 1'b0, 16'h0);

        phase = "boundary";
        while (m_cnt != 5) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h5555);
        while (m_cnt != FRAME - 1) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0F00);
        repeat (2 * FRAME + 2) step(1'b0, 1'b0, 16'h0);

        phase = "lz";
        lz_en = 1'b1;
        step(1'b0, 1'b1, 16'h0050);
        repeat (2 * FRAME) step(1'b0, 1'b0, 16'h0);
        phase = "mask";
        blank_mask = 4'b0001;
        repeat (FRAME) step(1'b0, 1'b0, 16'h0);
        phase = "dp";
        blank_mask = 4'b0000;
        dp_in = 4'b0010;
        repeat (FRAME) step(1'b0, 1'b0, 16'h0);
        lz_en = 1'b0;
        dp_in = 4'b0000;

        phase = "random";
        repeat (2000) begin
            rv = 16'h0;
            for (int k = 0; k < 4; k++) if ($urandom_range(1, 0) == 1) rv[4*k +: 4] = 4'($urandom);
            if ($urandom_range(15, 0) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(15, 0) == 0) dp_in = 4'($urandom);
            if ($urandom_range(31, 0) == 0) lz_en = ~lz_en;
            step(1'($urandom_range(399, 0) == 0), 1'($urandom_range(19, 0) == 0), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
